// File: rtl/pooling_array_2x2_cfg_if.sv
// Bundle of the pooling array's control, pixel-stream and result signals.
// The master side feeds pixels and configuration; the slave side is the pooling array.
interface pooling_array_2x2_cfg_if #(
  parameter int DATA_W = 16,
  parameter int COLS   = 32,
  parameter int MAX_W  = 64,
  parameter int MAX_H  = 64
);
  logic                               start;
  logic [$clog2(MAX_W+1)-1:0]         cfg_width;
  logic [$clog2(MAX_H+1)-1:0]         cfg_height;
  logic                               cfg_mode;
  logic                               in_valid;
  logic signed [DATA_W-1:0]           sys_out  [COLS];
  logic signed [DATA_W-1:0]           pool_out [COLS];
  logic [COLS-1:0]                    out_valid;
  logic [COLS-1:0]                    pool_done;
  logic                               busy;

  modport master (
    output start, cfg_width, cfg_height, cfg_mode, in_valid, sys_out,
    input  pool_out, out_valid, pool_done, busy
  );

  modport slave (
    input  start, cfg_width, cfg_height, cfg_mode, in_valid, sys_out,
    output pool_out, out_valid, pool_done, busy
  );
endinterface

// File: rtl/pooling_array_2x2_cfg.sv
// Per-column 2x2/stride-2 max or average pooling over a runtime-sized map.
// One FSM steers column 0; column j sees the same control through j skew registers.
module pooling_array_2x2_cfg #(
  parameter int DATA_W = 16,
  parameter int COLS   = 32,
  parameter int MAX_W  = 64,
  parameter int MAX_H  = 64
) (
  input logic                    clk,
  input logic                    rst,
  pooling_array_2x2_cfg_if.slave bus
);
  localparam int WW = $clog2(MAX_W + 1);
  localparam int HW = $clog2(MAX_H + 1);
  localparam int AW = (MAX_W > 2) ? $clog2(MAX_W / 2) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic          valid;
    logic          x_odd;
    logic          y_odd;
    logic [AW-1:0] addr;
    logic          mode;
    logic          last;
  } ctl_t;

  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_width;
  logic [HW-1:0] r_height;
  logic          r_mode;
  logic [WW-1:0] r_col_cnt;
  logic [HW-1:0] r_row_cnt;
  logic [CW-1:0] r_drain_cnt;
  logic          r_busy;

  logic          w_accept;
  logic          w_acc;
  logic          w_col_last;
  logic          w_row_last;
  logic [WW-1:0] w_cfg_w;
  logic [HW-1:0] w_cfg_h;
  logic [WW-1:0] w_w_even;
  logic [HW-1:0] w_h_even;
  ctl_t          w_col_ctl [COLS];

  assign w_accept   = (r_state == S_IDLE) && bus.start &&
                      (bus.cfg_width >= WW'(2)) && (bus.cfg_height >= HW'(2));
  assign w_acc      = (r_state == S_RUN) && bus.in_valid;
  assign w_cfg_w    = (bus.cfg_width  > WW'(MAX_W)) ? WW'(MAX_W) : bus.cfg_width;
  assign w_cfg_h    = (bus.cfg_height > HW'(MAX_H)) ? HW'(MAX_H) : bus.cfg_height;
  assign w_col_last = (r_col_cnt == r_width  - WW'(1));
  assign w_row_last = (r_row_cnt == r_height - HW'(1));
  // Odd trailing column/row are consumed but never paired.
  assign w_w_even   = {r_width[WW-1:1], 1'b0};
  assign w_h_even   = {r_height[HW-1:1], 1'b0};

  assign w_col_ctl[0].valid = w_acc && (r_col_cnt < w_w_even) && (r_row_cnt < w_h_even);
  assign w_col_ctl[0].x_odd = r_col_cnt[0];
  assign w_col_ctl[0].y_odd = r_row_cnt[0];
  assign w_col_ctl[0].addr  = AW'(r_col_cnt[WW-1:1]);
  assign w_col_ctl[0].mode  = r_mode;
  assign w_col_ctl[0].last  = (r_col_cnt == w_w_even - WW'(1)) && (r_row_cnt == w_h_even - HW'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN; else w_next = S_IDLE;
      S_RUN:   if (w_acc && w_col_last && w_row_last) w_next = S_DRAIN; else w_next = S_RUN;
      S_DRAIN: if (r_drain_cnt == CW'(COLS - 1)) w_next = S_IDLE; else w_next = S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_width     <= '0;
      r_height    <= '0;
      r_mode      <= 1'b0;
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      if (w_accept) begin
        r_width   <= w_cfg_w;
        r_height  <= w_cfg_h;
        r_mode    <= bus.cfg_mode;
        r_col_cnt <= '0;
        r_row_cnt <= '0;
      end else if (w_acc) begin
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : r_row_cnt + HW'(1);
        end else begin
          r_col_cnt <= r_col_cnt + WW'(1);
        end
      end
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CW'(1);
      else                    r_drain_cnt <= '0;
    end
  end

  assign bus.busy = r_busy;

  for (genvar j = 0; j < COLS; j++) begin : g_col
    ctl_t                     w_c;
    logic signed [DATA_W-1:0] w_pix;
    logic signed [DATA_W:0]   w_h_ext;
    logic signed [DATA_W:0]   w_p_ext;
    logic signed [DATA_W:0]   w_pair;
    logic signed [DATA_W:0]   w_lb;
    logic signed [DATA_W:0]   w_max4;
    logic signed [DATA_W+1:0] w_sum4;
    logic signed [DATA_W-1:0] w_res;
    logic signed [DATA_W-1:0] r_h;
    logic signed [DATA_W:0]   r_lb [MAX_W/2];
    logic signed [DATA_W-1:0] r_pool;
    logic                     r_ov;
    logic                     r_pd;

    if (j > 0) begin : g_skew
      ctl_t r_ctl;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ctl <= '0;
        else     r_ctl <= w_col_ctl[j-1];
      end
      assign w_col_ctl[j] = r_ctl;
    end

    assign w_c   = w_col_ctl[j];
    assign w_pix = bus.sys_out[j];

    always_comb begin
      w_h_ext = {r_h[DATA_W-1], r_h};
      w_p_ext = {w_pix[DATA_W-1], w_pix};
      w_lb    = r_lb[w_c.addr];
      w_pair  = w_p_ext;
      if (w_c.mode)              w_pair = w_h_ext + w_p_ext;
      else if (w_h_ext > w_p_ext) w_pair = w_h_ext;
      else                        w_pair = w_p_ext;
      w_sum4 = {w_pair[DATA_W], w_pair} + {w_lb[DATA_W], w_lb};
      w_max4 = (w_pair > w_lb) ? w_pair : w_lb;
      // Arithmetic shift floors toward -inf; a 4-pixel mean always fits DATA_W.
      if (w_c.mode) w_res = DATA_W'(w_sum4 >>> 2);
      else          w_res = DATA_W'(w_max4);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_h    <= '0;
        r_pool <= '0;
        r_ov   <= 1'b0;
        r_pd   <= 1'b0;
      end else begin
        r_ov <= w_c.valid && w_c.x_odd && w_c.y_odd;
        r_pd <= w_c.valid && w_c.x_odd && w_c.y_odd && w_c.last;
        if (w_c.valid && !w_c.x_odd) r_h <= w_pix;
        if (w_c.valid && w_c.x_odd && w_c.y_odd) r_pool <= w_res;
      end
    end

    // Line buffer holds even-row pair results; contents need no reset.
    always_ff @(posedge clk) begin
      if (w_c.valid && w_c.x_odd && !w_c.y_odd) r_lb[w_c.addr] <= w_pair;
    end

    assign bus.pool_out[j]  = r_pool;
    assign bus.out_valid[j] = r_ov;
    assign bus.pool_done[j] = r_pd;
  end
endmodule
